instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the RV32 core. Owns the PC and fetches instruction words from instruction memory over a grant/valid handshake.
- Presents instructions, with the decode fields pre-split, to the control unit.
- Consumes the control unit's PCSrc and the branch target.
- One-deep prefetch: speculatively fetches PC+4 while the current instruction waits, and squashes it on a taken branch.

Parameters:
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, PC loaded at reset
- NOP_INSTR, 32'h0000_0013, value driven on instr when instr_valid=0 (addi x0,x0,0)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  word-aligned fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid (>=1 cycle after gnt, in order)
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instruction presented to decode
- instr_ready  in  1  decode accepts the presented instruction
- instr  out  32  instruction word
- pc_out  out  XLEN  PC of the presented instruction
- op  out  7  instr[6:0]
- funct3  out  3  instr[14:12]
- funct7  out  1  instr[30]
- pc_src  in  1  taken branch for the accepted instruction
- pc_target  in  XLEN  branch target (PC + ImmExt)
- misalign_err  out  1  sticky: target had bits[1:0]!=0

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; state=IDLE; instr_valid=0; instr=NOP_INSTR; pc_out=RESET_PC; imem_req=0; misalign_err=0; stale=0.
  - Any outstanding request is forgotten; a rvalid arriving after release with no request outstanding is ignored.
- Fetch FSM, single outstanding request:
  - IDLE: entered one cycle after reset release; goes to REQ.
  - REQ: imem_req=1, imem_addr=fetch_pc, held stable until imem_gnt. On gnt: fetch_pc+=4, go WAIT.
  - WAIT: imem_req=0.
    - On imem_rvalid with stale=1: drop the data, clear stale, go REQ.
    - On imem_rvalid with stale=0 and the output register free (or freed this cycle by accept): load the output register (instr, pc_out=address fetched, instr_valid=1), go REQ.
    - On imem_rvalid with the output register still occupied: data goes to a 1-entry skid register, go FULL.
  - FULL: no request. When the output is accepted, the skid entry moves to the output register the same edge, go REQ.
- Output register:
  - Holds instr, pc_out and fields stable while instr_valid && !instr_ready.
  - On accept (instr_valid && instr_ready) with no new data the same edge: instr_valid=0, instr=NOP_INSTR.
  - op, funct3 and funct7 are combinational slices of instr.
- Redirect: acts only on an accept cycle with pc_src=1. pc_src without accept is ignored.
  - fetch_pc=pc_target & ~3, and the skid entry is invalidated.
  - If a request is in WAIT, stale=1.
  - If in REQ with gnt the same cycle, stale=1.
  - If in REQ without gnt, imem_addr switches to the new PC the next cycle. This is the only allowed change of imem_addr while imem_req is held.
  - If the same-cycle rvalid would load the output, that data is dropped.
  - If pc_target[1:0]!=0, misalign_err is set (sticky until reset). Fetch proceeds from the aligned address.
- Latency:
  - First instr_valid at the earliest 2 cycles after imem_gnt at 1-cycle memory latency.
  - Steady-state throughput: one instruction per cycle is NOT required. Throughput is 1 per 2 cycles at 1-cycle memory latency, with no bubbles beyond that.
- PC arithmetic wraps modulo 2^XLEN: 32'hFFFF_FFFC+4 -> 0, no flag.
- rst_n asserted mid-WAIT returns to the reset state immediately. The first post-reset request is at RESET_PC.

Test Plan:
- Reset then imem_gnt=1 always, 1-cycle rvalid, instr_ready=1, memory returns addr-derived words -> imem_addr sequence 0,4,8,C; pc_out matches each; instr at 0x0 = 32'h00500093 gives op=7'h13, funct3=0, funct7=0.
- Hold instr_ready=0 for 6 cycles with an instruction presented -> instr and pc_out stable, exactly one prefetch (pc_out+4) issued, FSM in FULL, no further imem_req; on release, next instruction appears the following cycle.
- Accept instr at 0x10 with pc_src=1, pc_target=0x40 while fetch of 0x14 is in WAIT -> 0x14 data discarded, next imem_addr=0x40, next pc_out=0x40, 0x14 never presented.
- pc_src=1 without instr_ready -> no redirect, sequential fetch continues.
- pc_target=0x42 on redirect -> misalign_err=1 and stays 1; fetch from 0x40.
- Assert rst_n=0 mid-WAIT, then rvalid arrives during reset -> all outputs at reset values, and the first request after release is RESET_PC.
- Set RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus: grant/valid handshake, one word per beat.
interface instr_fetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32 fetch front end: owns the PC, one outstanding imem request, one-deep prefetch
// through a skid entry, redirect on taken branches with squash of in-flight data.
module instr_fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  imem,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [31:0]         instr,
  output logic [XLEN-1:0]     pc_out,
  output logic [6:0]          op,
  output logic [2:0]          funct3,
  output logic                funct7,
  input  logic                pc_src,
  input  logic [XLEN-1:0]     pc_target,
  output logic                misalign_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StFull} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            stale_q, stale_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            misalign_q, misalign_d;

  logic            accept;
  logic            redirect;
  logic            resp_ok;
  logic [XLEN-1:0] target_aligned;

  assign accept         = out_valid_q & instr_ready;
  assign redirect       = accept & pc_src;
  assign target_aligned = {pc_target[XLEN-1:2], 2'b00};
  // A response is usable only if it is not stale and not squashed by this cycle's redirect
  assign resp_ok        = (state_q == StWait) & imem.imem_rvalid & ~stale_q & ~redirect;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: state_d = StReq;
      StReq:  if (imem.imem_gnt) state_d = StWait;
      StWait: begin
        if (imem.imem_rvalid) begin
          if (resp_ok && out_valid_q && !accept) state_d = StFull;
          else                                   state_d = StReq;
        end
      end
      StFull: if (accept) state_d = StReq;
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs: address is the fetch PC and only moves on grant or redirect
  always_comb begin
    imem.imem_req  = (state_q == StReq);
    imem.imem_addr = fetch_pc_q;
  end

  // Datapath next-state: PC, stale flag, output and skid registers
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    stale_d      = stale_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    misalign_d   = misalign_q;

    if (state_q == StReq && imem.imem_gnt) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
    if (redirect) begin
      fetch_pc_d = target_aligned;
      if (pc_target[1:0] != 2'b00) misalign_d = 1'b1;
    end

    if (state_q == StWait && imem.imem_rvalid) stale_d = 1'b0;
    // The granted or in-flight request belongs to the wrong path
    if (redirect && ((state_q == StWait && !imem.imem_rvalid) ||
                     (state_q == StReq && imem.imem_gnt))) begin
      stale_d = 1'b1;
    end

    if (accept) begin
      out_valid_d = 1'b0;
      out_instr_d = NOP_INSTR;
    end
    if (resp_ok && (!out_valid_q || accept)) begin
      out_valid_d = 1'b1;
      out_instr_d = imem.imem_rdata;
      out_pc_d    = req_pc_q;
    end else if (resp_ok) begin
      skid_instr_d = imem.imem_rdata;
      skid_pc_d    = req_pc_q;
    end else if (state_q == StFull && accept && !redirect) begin
      out_valid_d = 1'b1;
      out_instr_d = skid_instr_q;
      out_pc_d    = skid_pc_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= RESET_PC;
      stale_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP_INSTR;
      out_pc_q     <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= RESET_PC;
      misalign_q   <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      stale_q      <= stale_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      misalign_q   <= misalign_d;
    end
  end

  assign instr_valid  = out_valid_q;
  assign instr        = out_instr_q;
  assign pc_out       = out_pc_q;
  assign op           = out_instr_q[6:0];
  assign funct3       = out_instr_q[14:12];
  assign funct7       = out_instr_q[30];
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: program-order reference model plus a queue-based memory.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        instr_ready, pc_src;
  logic [31:0] pc_target;
  logic        instr_valid, funct7, misalign_err;
  logic [31:0] instr, pc_out;
  logic [6:0]  op;
  logic [2:0]  funct3;

  // Second instance with a wrap-around reset PC
  logic        ready2, src2, valid2, f7_2, mis2;
  logic [31:0] tgt2, instr2, pc2;
  logic [6:0]  op2;
  logic [2:0]  f3_2;

  instr_fetch_unit_if #(.XLEN(32)) bus ();
  instr_fetch_unit_if #(.XLEN(32)) bus2 ();

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (bus),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .pc_out       (pc_out),
    .op           (op),
    .funct3       (funct3),
    .funct7       (funct7),
    .pc_src       (pc_src),
    .pc_target    (pc_target),
    .misalign_err (misalign_err)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (bus2),
    .instr_valid  (valid2),
    .instr_ready  (ready2),
    .instr        (instr2),
    .pc_out       (pc2),
    .op           (op2),
    .funct3       (f3_2),
    .funct7       (f7_2),
    .pc_src       (src2),
    .pc_target    (tgt2),
    .misalign_err (mis2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  int unsigned vectors, miscompares, cyc, gnt_count;
  int unsigned gnt_pct, lat_min, lat_max;
  pend_t       pend[$];
  logic [31:0] gnt2_q[$];
  logic [31:0] exp_pc, last_gnt_addr, addr_prev, base_pc, tgt;
  bit          exp_mis, hold_prev, r2, done, held, found;
  int unsigned base_gnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: compare against model, drive memory and decode inputs, advance to next negedge
  task automatic cycle(input bit rdy, input bit src, input logic [31:0] t);
    logic [31:0] w;
    bit          acc;
    w = mem_word(exp_pc);
    if (hold_prev) begin
      check("req_held", 32'(bus.imem_req), 32'd1);
      check("addr_held", bus.imem_addr, addr_prev);
    end
    check("misalign", 32'(misalign_err), 32'(exp_mis));
    if (instr_valid) begin
      check("pc_out", pc_out, exp_pc);
      check("instr", instr, w);
      check("fields", 32'({op, funct3, funct7}), 32'({w[6:0], w[14:12], w[30]}));
    end else begin
      check("nop", instr, NOP);
    end

    bus.imem_gnt = bus.imem_req && ($urandom_range(99) < gnt_pct);
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    if (bus.imem_gnt) begin
      pend.push_back('{addr: bus.imem_addr, due: cyc + $urandom_range(lat_max, lat_min)});
      gnt_count++;
      last_gnt_addr = bus.imem_addr;
    end

    instr_ready = rdy;
    pc_src      = src;
    pc_target   = t;
    acc         = instr_valid && rdy;
    hold_prev   = bus.imem_req && !bus.imem_gnt && !(acc && src);
    addr_prev   = bus.imem_addr;
    if (acc) begin
      if (src) begin
        exp_pc = t & ~32'h3;
        if (t[1:0] != 2'b00) exp_mis = 1'b1;
      end else begin
        exp_pc = exp_pc + 32'd4;
      end
    end

    bus2.imem_gnt    = 1'b1;
    bus2.imem_rvalid = r2;
    bus2.imem_rdata  = NOP;
    if (bus2.imem_req) gnt2_q.push_back(bus2.imem_addr);
    r2 = bus2.imem_req;

    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus.imem_gnt     = 1'b0;
    bus.imem_rvalid  = 1'b0;
    bus.imem_rdata   = '0;
    bus2.imem_gnt    = 1'b0;
    bus2.imem_rvalid = 1'b0;
    bus2.imem_rdata  = '0;
    instr_ready      = 1'b0;
    pc_src           = 1'b0;
    pc_target        = '0;
    pend.delete();
    gnt2_q.delete();
    r2        = 1'b0;
    hold_prev = 1'b0;
    exp_pc    = 32'h0;
    exp_mis   = 1'b0;
    @(negedge clk);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc_out, 32'h0);
    check("rst_mis", 32'(misalign_err), 32'd0);
    check("rst2_pc", pc2, 32'hFFFF_FFFC);
    check("rst2_out", {valid2, mis2, bus2.imem_req, instr2[28:0]}, {3'b000, NOP[28:0]});
    check("rst2_fields", 32'({op2, f3_2, f7_2}), 32'({NOP[6:0], NOP[14:12], NOP[30]}));
    // Stray response while in reset must be ignored
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rst_stray", 32'(instr_valid), 32'd0);
    bus.imem_rvalid = 1'b0;
    rst_n           = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 30 && !instr_valid; i++) cycle(1'b1, 1'b0, 32'h0);
    check(tag, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; gnt_count = 0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    ready2 = 1'b1; src2 = 1'b0; tgt2 = '0;
    rst_n = 1'b0;
    do_reset();

    // Sequential fetch at 1-cycle memory: request every other cycle, first data 2 cycles later
    for (int k = 0; k < 9; k++) begin
      check("tp_req", 32'(bus.imem_req), 32'(k % 2 == 1));
      if (k % 2 == 1) check("tp_addr", bus.imem_addr, 32'((k - 1) * 2));
      check("tp_valid", 32'(instr_valid), 32'(k >= 3 && k % 2 == 1));
      if (k == 3) check("dec_fields", 32'({op, funct3, funct7}), {21'd0, 7'h13, 3'd0, 1'b0});
      cycle(1'b1, 1'b0, 32'h0);
    end
    check("wrap_cnt", 32'(gnt2_q.size() >= 2), 32'd1);
    if (gnt2_q.size() >= 2) begin
      check("wrap_a0", gnt2_q[0], 32'hFFFF_FFFC);
      check("wrap_a1", gnt2_q[1], 32'h0000_0000);
    end

    // Decode stall: exactly one prefetch, then the skid entry follows on release
    wait_valid("stall_wait");
    base_gnt = gnt_count;
    base_pc  = exp_pc;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0);
    check("stall_gnts", gnt_count - base_gnt, 32'd1);
    check("stall_pref", last_gnt_addr, base_pc + 32'd4);
    check("stall_noreq", 32'(bus.imem_req), 32'd0);
    check("stall_valid", 32'(instr_valid), 32'd1);
    cycle(1'b1, 1'b0, 32'h0);
    check("release_valid", 32'(instr_valid), 32'd1);
    check("release_pc", pc_out, base_pc + 32'd4);

    // pc_src without accept is ignored
    wait_valid("nosrc_wait");
    cycle(1'b0, 1'b1, 32'h80);
    cycle(1'b1, 1'b0, 32'h0);
    wait_valid("nosrc_next");

    // Redirect from 0x10 to 0x40 while the 0x14 fetch is in flight
    do_reset();
    lat_min = 2; lat_max = 2;
    done = 1'b0; held = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      if (instr_valid && pc_out == 32'h10 && !held) begin
        held = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
      end else if (instr_valid && pc_out == 32'h10) begin
        done = 1'b1;
        cycle(1'b1, 1'b1, 32'h40);
      end else begin
        cycle(1'b1, 1'b0, 32'h0);
      end
    end
    check("redir_reached", 32'(done), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.imem_req) found = 1'b1;
      else cycle(1'b1, 1'b0, 32'h0);
    end
    check("redir_req_seen", 32'(found), 32'd1);
    check("redir_addr", bus.imem_addr, 32'h40);
    wait_valid("redir_wait");
    check("redir_pc", pc_out, 32'h40);

    // Misaligned target: sticky flag, fetch from aligned address
    lat_min = 1; lat_max = 1;
    wait_valid("mis_wait");
    cycle(1'b1, 1'b1, 32'h42);
    wait_valid("mis_next");
    check("mis_pc", pc_out, 32'h40);
    check("mis_flag", 32'(misalign_err), 32'd1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'(($urandom_range(3) == 0)), 32'h100);
    check("mis_sticky", 32'(misalign_err), 32'd1);

    // Reset in the middle of an outstanding request
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 30 && !(pend.size() != 0 && !bus.imem_req); i++) cycle(1'b1, 1'b0, 32'h0);
    check("midwait_reached", 32'(pend.size() != 0 && !bus.imem_req), 32'd1);
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.imem_req) found = 1'b1;
      else cycle(1'b1, 1'b0, 32'h0);
    end
    check("post_rst_req", 32'(found), 32'd1);
    check("post_rst_addr", bus.imem_addr, 32'h0);

    // Randomized traffic against the program-order model
    gnt_pct = 70; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 2000; i++) begin
      tgt = 32'($urandom_range(511)) << 2;
      if ($urandom_range(9) == 0) tgt[1:0] = 2'($urandom_range(3));
      if ($urandom_range(19) == 0) tgt = 32'hFFFF_FFF0 | {28'd0, tgt[3:0]};
      cycle(1'($urandom_range(99) < 70), 1'($urandom_range(99) < 20), tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
